instruction_fetch_unit: RTL and testbench

Initiator side of the instruction-memory read interface. It owns the fetch PC, drives the PC to the combinational instruction memory, and captures each returned word together with its PC. Captured entries go into a small fetch queue and are handed to decode over a valid/ready handshake. Branch/jump redirects from later stages flush the queue and reload the PC.

---
 rtl/instruction_fetch_unit.sv | 58 +++++
 tb/tb_instruction_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: drives the fetch PC to instruction memory and queues returned words for decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_enable,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    logic [31:0] fetch_pc;
    logic [31:0] pc_q  [QUEUE_DEPTH];
    logic [31:0] ins_q [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic deq, enq;
    assign imem_pc = fetch_pc;
    assign out_valid = count != '0;
    assign out_instruction = out_valid ? ins_q[rd_ptr] : 32'h0000_0013;
    assign out_pc = out_valid ? pc_q[rd_ptr] : 32'h0;
    assign deq = out_valid & out_ready;
    // count can only reach QUEUE_DEPTH (a power of two) when its top bit is set
    assign enq = fetch_enable & ~redirect_valid & (~count[PW] | deq);
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[wr_ptr] <= fetch_pc;
            ins_q[wr_ptr] <= imem_instruction;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random fetch traffic checked against a queue-based reference model.
module tb_instruction_fetch_unit;
    localparam int D = 2;
    logic clk = 1'b0;
    logic reset, fetch_enable, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc, imem_instruction, out_instruction, out_pc;
    logic out_valid;
    logic [31:0] imem_pc2, imem_instruction2, out_instruction2, out_pc2;
    logic out_valid2;
    typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
    ent_t q[$];
    logic [31:0] mpc;
    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] wrap_exp [4];

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .imem_pc(imem_pc), .imem_instruction(imem_instruction),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(D)) dut2 (
        .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
        .imem_pc(imem_pc2), .imem_instruction(imem_instruction2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_instruction(out_instruction2), .out_pc(out_pc2)
    );

    assign imem_instruction = imem_pc | 32'h1;
    assign imem_instruction2 = imem_pc2 | 32'h1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        fetch_enable = fe;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic advance();
        ent_t h;
        bit full, deq;
        if (q.size() != 0) h = q[0];
        else begin
            h.pc = 32'h0;
            h.ins = 32'h0000_0013;
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("out_pc", out_pc, h.pc);
        chk("out_instruction", out_instruction, h.ins);
        chk("imem_pc", imem_pc, mpc);
        full = q.size() >= D;
        deq = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc & ~32'h3;
        end else if (fetch_enable && (!full || deq)) begin
            q.push_back('{mpc, mpc | 32'h1});
            mpc += 32'd4;
        end
        #1;
    endtask

    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        drive(fe, rv, rpc, rdy);
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        mpc = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        fetch_enable = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        do_reset();
        // free-running stream; the second instance exercises the PC wrap
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            chk("wrap_valid", {31'b0, out_valid2}, {31'b0, k >= 2});
            if (k >= 2 && k <= 5) begin
                chk("wrap_pc", out_pc2, wrap_exp[k-2]);
                chk("wrap_ins", out_instruction2, wrap_exp[k-2] | 32'h1);
            end
            advance();
        end
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0202, 1'b1);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFF6, 1'b0);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF)),
                 $urandom_range(0, 2) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
